// File: rtl/vliw_pkg.sv
// Shared fetch-path types: bundle/address widths, fetch FSM states
// and the {pc, bundle} entry stored in the fetch buffer.
package vliw_pkg;

  localparam int BUNDLE_W = 128;
  localparam int ADDR_W   = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FULL
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]   pc;
    logic [BUNDLE_W-1:0] bundle;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Bundle buffer between memory response and decode.
// Flush drops all entries; storage is cleared only by reset.
module fetch_fifo
  import vliw_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  output logic [CNT_W-1:0]   count,
  output fetch_entry_t       head
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_entry;
        wr_d        = wr_q + 1'b1;
      end
      if (pop) begin
        rd_d = rd_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_q];

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst)
    !(push && !flush && count_q == FULL_CNT));

  a_no_underflow: assert property (
    @(posedge clk) disable iff (!rst)
    !(pop && !flush && count_q == '0));

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: PC sequencing, one-cycle memory handshake,
// credit-based issue into the bundle buffer, redirect flush.
module inst_fetch_unit
  import vliw_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] BUNDLE_STEP = 32'd1,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_en,
  output logic [ADDR_W-1:0]   pc_out,
  input  logic [BUNDLE_W-1:0] inst_bundle_in,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                bundle_valid,
  output logic [BUNDLE_W-1:0] bundle_data,
  output logic [ADDR_W-1:0]   bundle_pc,
  input  logic                bundle_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] OCC_MAX = (CNT_W+1)'(FIFO_DEPTH);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
  logic              inflight_q, inflight_d;

  logic [CNT_W-1:0]  count;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;
  logic              push, pop, issue;
  logic [CNT_W:0]    occ, next_occ;

  assign bundle_valid = (count != '0);
  assign pop          = bundle_valid & bundle_ready;
  assign push         = inflight_q & ~redirect_valid;
  assign push_entry   = '{pc: infl_pc_q, bundle: inst_bundle_in};

  // Credits count buffered plus in-flight bundles; pops this cycle
  // are not reused for issue.
  assign occ   = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
  assign issue = (state_q == FETCH) && fetch_en &&
                 !redirect_valid && (occ < OCC_MAX);
  assign next_occ = occ - {{CNT_W{1'b0}}, pop}
                        + {{CNT_W{1'b0}}, issue};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    infl_pc_d  = infl_pc_q;
    inflight_d = issue;
    if (issue) begin
      pc_d      = pc_q + BUNDLE_STEP;
      infl_pc_d = pc_q;
    end
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = fetch_en ? FETCH : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fetch_en) state_d = FETCH;
        end
        FETCH: begin
          if (!fetch_en)                state_d = IDLE;
          else if (next_occ >= OCC_MAX) state_d = FULL;
        end
        FULL: begin
          if (!fetch_en)               state_d = IDLE;
          else if (next_occ < OCC_MAX) state_d = FETCH;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      infl_pc_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      infl_pc_q  <= infl_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign pc_out      = pc_q;
  assign bundle_data = head.bundle;
  assign bundle_pc   = head.pc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: per-cycle vector table
// plus hand sequences for redirect, reset-while-full and PC wrap.
module tb_inst_fetch_unit;

  logic         clk;
  logic         rst;
  logic         fetch_en;
  logic [31:0]  pc_out;
  logic [127:0] mem_q;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         bundle_valid;
  logic [127:0] bundle_data;
  logic [31:0]  bundle_pc;
  logic         bundle_ready;

  logic         fen2;
  logic [31:0]  pc2;
  logic [127:0] mem2_q;
  logic         rv2;
  logic [31:0]  rpc2;
  logic         v2;
  logic [127:0] d2;
  logic [31:0]  bpc2;
  logic         rdy2;

  int checks = 0;
  int errors = 0;

  inst_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_en      (fetch_en),
    .pc_out        (pc_out),
    .inst_bundle_in(mem_q),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .bundle_valid  (bundle_valid),
    .bundle_data   (bundle_data),
    .bundle_pc     (bundle_pc),
    .bundle_ready  (bundle_ready)
  );

  inst_fetch_unit #(
    .RESET_PC(32'hFFFF_FFFF)
  ) dut2 (
    .clk           (clk),
    .rst           (rst),
    .fetch_en      (fen2),
    .pc_out        (pc2),
    .inst_bundle_in(mem2_q),
    .redirect_valid(rv2),
    .redirect_pc   (rpc2),
    .bundle_valid  (v2),
    .bundle_data   (d2),
    .bundle_pc     (bpc2),
    .bundle_ready  (rdy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] bundle_of(input logic [31:0] pc);
    return {pc, ~pc, pc ^ 32'h5A5A_A5A5, 32'hB0B0_0000 + pc};
  endfunction

  // One-cycle-latency memory models
  always @(posedge clk) begin
    mem_q  <= bundle_of(pc_out);
    mem2_q <= bundle_of(pc2);
  end

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        fen;
    logic        rdy;
    logic [31:0] epc;
    logic        ev;
    logic [31:0] ebpc;
    logic        efull;
    logic        chk;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, input logic f,
                              input logic d, input logic [31:0] pc,
                              input logic v, input logic [31:0] bpc,
                              input logic full, input logic c);
    vec_t x;
    x.rst = r; x.fen = f; x.rdy = d; x.epc = pc;
    x.ev = v; x.ebpc = bpc; x.efull = full; x.chk = c;
    return x;
  endfunction

  initial begin
    rst = 1'b0; fetch_en = 1'b0; bundle_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    fen2 = 1'b0; rv2 = 1'b0; rpc2 = '0; rdy2 = 1'b1;

    // Streaming, fetch_en gap of 3 cycles
    vq.push_back(mk(1,1,1, 0, 0,0, 0,1));
    vq.push_back(mk(1,1,1, 0, 0,0, 0,1));
    vq.push_back(mk(1,1,1, 1, 0,0, 0,1));
    vq.push_back(mk(1,1,1, 2, 1,0, 0,1));
    vq.push_back(mk(1,1,1, 3, 1,1, 0,1));
    vq.push_back(mk(1,1,1, 4, 1,2, 0,1));
    vq.push_back(mk(1,1,1, 5, 1,3, 0,1));
    vq.push_back(mk(1,0,1, 6, 1,4, 0,1));
    vq.push_back(mk(1,0,1, 6, 1,5, 0,1));
    vq.push_back(mk(1,0,1, 6, 0,0, 0,1));
    vq.push_back(mk(1,1,1, 6, 0,0, 0,1));
    vq.push_back(mk(1,1,1, 6, 0,0, 0,1));
    vq.push_back(mk(1,1,1, 7, 0,0, 0,1));
    vq.push_back(mk(1,1,1, 8, 1,6, 0,1));
    vq.push_back(mk(1,1,1, 9, 1,7, 0,1));
    // Reset mid-stream, then backpressure to FULL and drain
    vq.push_back(mk(0,1,0, 0, 0,0, 0,0));
    vq.push_back(mk(1,1,0, 0, 0,0, 0,1));
    vq.push_back(mk(1,1,0, 0, 0,0, 0,1));
    vq.push_back(mk(1,1,0, 1, 0,0, 0,1));
    vq.push_back(mk(1,1,0, 2, 1,0, 0,1));
    vq.push_back(mk(1,1,0, 3, 1,0, 0,1));
    vq.push_back(mk(1,1,0, 4, 1,0, 1,1));
    vq.push_back(mk(1,1,0, 4, 1,0, 1,1));
    vq.push_back(mk(1,1,0, 4, 1,0, 1,1));
    vq.push_back(mk(1,1,1, 4, 1,0, 1,1));
    vq.push_back(mk(1,1,1, 4, 1,1, 0,1));
    vq.push_back(mk(1,1,1, 5, 1,2, 0,1));
    vq.push_back(mk(1,1,1, 6, 1,3, 0,1));
    vq.push_back(mk(1,1,1, 7, 1,4, 0,1));
    vq.push_back(mk(1,1,1, 8, 1,5, 0,1));

    // Reset state
    tick();
    tick();
    check("rst pc_out", 128'(pc_out), 128'(32'h0));
    check("rst valid", 128'(bundle_valid), 128'(1'b0));
    check("rst data", bundle_data, 128'h0);
    check("rst bpc", 128'(bundle_pc), 128'(32'h0));
    check("rst pc2", 128'(pc2), 128'(32'hFFFF_FFFF));

    foreach (vq[i]) begin
      rst          = vq[i].rst;
      fetch_en     = vq[i].fen;
      bundle_ready = vq[i].rdy;
      if (vq[i].chk) begin
        check($sformatf("row%0d pc_out", i),
              128'(pc_out), 128'(vq[i].epc));
        check($sformatf("row%0d valid", i),
              128'(bundle_valid), 128'(vq[i].ev));
        check($sformatf("row%0d full", i),
              128'(dut.state_q == vliw_pkg::FULL),
              128'(vq[i].efull));
        if (vq[i].ev) begin
          check($sformatf("row%0d bpc", i),
                128'(bundle_pc), 128'(vq[i].ebpc));
          check($sformatf("row%0d data", i),
                bundle_data, bundle_of(vq[i].ebpc));
        end
      end
      tick();
    end

    // Redirect with 3 buffered + 1 in flight
    rst = 1'b0; fetch_en = 1'b1; bundle_ready = 1'b0;
    tick();
    rst = 1'b1;
    repeat (5) tick();
    check("pre-redir full", 128'(dut.state_q == vliw_pkg::FULL),
          128'(1'b1));
    check("pre-redir pc", 128'(pc_out), 128'(32'd4));
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0; bundle_ready = 1'b1;
    check("redir valid", 128'(bundle_valid), 128'(1'b0));
    check("redir pc", 128'(pc_out), 128'(32'h40));
    check("redir fetch", 128'(dut.state_q == vliw_pkg::FETCH),
          128'(1'b1));
    tick();
    check("redir+1 pc", 128'(pc_out), 128'(32'h41));
    check("redir+1 valid", 128'(bundle_valid), 128'(1'b0));
    tick();
    check("redir+2 valid", 128'(bundle_valid), 128'(1'b1));
    check("redir+2 bpc", 128'(bundle_pc), 128'(32'h40));
    check("redir+2 data", bundle_data, bundle_of(32'h40));
    tick();
    check("redir+3 bpc", 128'(bundle_pc), 128'(32'h41));

    // Reset while FULL with a response in flight
    rst = 1'b0; fetch_en = 1'b1; bundle_ready = 1'b0;
    tick();
    rst = 1'b1;
    repeat (5) tick();
    check("pre-rst full", 128'(dut.state_q == vliw_pkg::FULL),
          128'(1'b1));
    rst = 1'b0;
    tick();
    check("mid-rst pc", 128'(pc_out), 128'(32'h0));
    check("mid-rst valid", 128'(bundle_valid), 128'(1'b0));
    check("mid-rst data", bundle_data, 128'h0);
    check("mid-rst bpc", 128'(bundle_pc), 128'(32'h0));
    check("mid-rst idle", 128'(dut.state_q == vliw_pkg::IDLE),
          128'(1'b1));
    rst = 1'b1; bundle_ready = 1'b1;
    tick();
    tick();
    check("post-rst c2 valid", 128'(bundle_valid), 128'(1'b0));
    tick();
    check("post-rst c3 valid", 128'(bundle_valid), 128'(1'b1));
    check("post-rst c3 bpc", 128'(bundle_pc), 128'(32'h0));
    check("post-rst c3 data", bundle_data, bundle_of(32'h0));

    // PC wrap on the second instance
    fetch_en = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1; fen2 = 1'b1;
    check("wrap c0 pc", 128'(pc2), 128'(32'hFFFF_FFFF));
    tick();
    check("wrap c1 pc", 128'(pc2), 128'(32'hFFFF_FFFF));
    tick();
    check("wrap c2 pc", 128'(pc2), 128'(32'h0000_0000));
    tick();
    check("wrap c3 pc", 128'(pc2), 128'(32'h0000_0001));
    check("wrap c3 valid", 128'(v2), 128'(1'b1));
    check("wrap c3 bpc", 128'(bpc2), 128'(32'hFFFF_FFFF));
    check("wrap c3 data", d2, bundle_of(32'hFFFF_FFFF));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
